fft_bin_reader: RTL and testbench
=================================

FFT_BIN_READER -- requirements
Module: fft_bin_reader

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 10, meaning log2 of FFT length N (bin index and address width).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning packed bin word width ({re,im}).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse: FFT frame in bin RAM is complete, begin readout.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-008 mem_rd_en  output  1  bin RAM read strobe.
REQ-009 mem_rd_addr  output  BIT_WIDTH  bin RAM read address.
REQ-010 mem_rd_data  input  DATA_WIDTH  RAM data, valid exactly one cycle after mem_rd_en.
REQ-011 m_valid  output  1  output beat valid.
REQ-012 m_ready  input  1  downstream ready.
REQ-013 m_data  output  DATA_WIDTH  bin word.
REQ-014 m_index  output  BIT_WIDTH  natural-order bin index of m_data.
REQ-015 m_last  output  1  high with the beat for index N-1.

Function
REQ-016 FSM states IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN after read for index N-1 issued; DRAIN->IDLE when buffer empty and no read outstanding, asserting done that cycle.
REQ-017 start outside IDLE SHALL be ignored (no restart, no effect on current frame).
REQ-018 Index counter SHALL clear on entering READ and increment by 1 per issued read, no wrap within a frame.
REQ-019 mem_rd_en SHALL be combinational from state/credits; issue allowed only when (buffer occupancy + outstanding reads - pop this cycle) < 2.
REQ-020 Returned data and its index SHALL be written into a 2-entry output FIFO; m_valid = FIFO not empty.
REQ-021 Transfer occurs when m_valid && m_ready; m_data/m_index/m_last SHALL stay stable while m_valid && !m_ready.
REQ-022 Latency: start in cycle 0 -> mem_rd_en with index 0 in cycle 1 -> m_valid in cycle 3.
REQ-023 With m_ready held high, throughput SHALL be one beat per cycle; frame of N beats completes with done in cycle N+3.
REQ-024 Beats SHALL emerge in strictly increasing m_index 0..N-1, exactly N per frame, no drops or duplicates under arbitrary m_ready.
REQ-025 m_ready may be low indefinitely; no reads SHALL issue while FIFO is full.

Reset
REQ-026 Reset SHALL return FSM to IDLE, flush FIFO, clear counter and outstanding flag, even mid-frame.
REQ-027 Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, m_valid=0, m_data=0, m_index=0, m_last=0.
REQ-028 Data returning the cycle after reset SHALL be discarded.

Configuration
REQ-029 Macro FFT_BIN_READER_BITREV_EN: when defined, mem_rd_addr SHALL be the bit-reversal of the index counter (RAM holds bit-reversed FFT output); m_index stays natural order.
REQ-030 Without FFT_BIN_READER_BITREV_EN, mem_rd_addr SHALL equal the index counter.

Structure
REQ-031 Shared package fft_pkg SHALL hold the FSM state enum and default BIT_WIDTH/DATA_WIDTH constants.
REQ-032 Output FIFO SHALL be sub-module fft_bin_skid_fifo (2-entry, valid/ready).

Verification (BIT_WIDTH=4, N=16, RAM word at address a = 0xA000+a)
REQ-033 start, m_ready=1 -> mem_rd_en cycle 1, m_valid cycle 3, 16 beats back-to-back, m_last on index 15, done cycle 19.
REQ-034 With BITREV_EN, m_ready=1 -> beat index 1 carries 0xA008, index 3 carries 0xA00C; without macro index 1 carries 0xA001.
REQ-035 m_ready random 30% -> 16 in-order beats, data stable under stall, never more than 2 buffered, done once.
REQ-036 start pulsed again at cycle 5 during frame -> ignored, exactly 16 beats, one done.
REQ-037 reset asserted at beat 7 -> all outputs 0 next cycle, FSM IDLE; new start yields full frame from index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bin readout path: FSM state encoding and
// default geometry (log2 FFT length, packed {re,im} bin word width).
package fft_pkg;

    localparam int FFT_BIT_WIDTH  = 10;
    localparam int FFT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fft_state_e;

endpackage

// File: rtl/fft_bin_skid_fifo.sv
// Two-entry valid/ready output FIFO. The head entry stays put while the
// consumer stalls, so rd_data is stable whenever rd_valid && !rd_ready.
module fft_bin_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [1:0]       count,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign rd_valid = (count != 2'd0);
    assign rd_data  = mem[rd_ptr];
    assign pop      = rd_valid && rd_ready;
    assign push     = wr_en && (count != 2'd2);

    // Storage, pointers and occupancy; reset zeroes the entries so outputs read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fft_bin_reader.sv
// Streams one FFT frame out of the bin RAM in natural bin order.
// Reads are credit-limited so the 2-entry output FIFO can never overflow,
// giving one beat per cycle when downstream is always ready.
// Build option: define FFT_BIN_READER_BITREV_EN when the RAM holds the
// FFT output in bit-reversed order; addresses are then bit-reversed while
// m_index stays in natural order.
module fft_bin_reader
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH  = FFT_BIT_WIDTH,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [BIT_WIDTH-1:0]  mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [BIT_WIDTH-1:0]  m_index,
    output logic                  m_last
);

    localparam int                   PW       = DATA_WIDTH + BIT_WIDTH + 1;
    localparam logic [BIT_WIDTH-1:0] LAST_IDX = '1;

    fft_state_e           state;
    logic [BIT_WIDTH-1:0] idx;
    logic [BIT_WIDTH-1:0] pend_idx;
    logic                 rd_pending;
    logic [1:0]           fifo_count;
    logic                 pop;
    logic [2:0]           credit_use;
    logic [PW-1:0]        fifo_wr_data;
    logic [PW-1:0]        fifo_rd_data;

    assign pop        = m_valid && m_ready;
    // A pop implies at least one buffered entry, so this never underflows.
    assign credit_use = 3'(fifo_count) + 3'(rd_pending) - 3'(pop);
    assign mem_rd_en  = (state == READ) && (credit_use < 3'd2);

`ifdef FFT_BIN_READER_BITREV_EN
    // RAM holds bit-reversed order: mirror the natural index onto the address.
    always_comb begin
        mem_rd_addr = '0;
        for (int unsigned b = 0; b < BIT_WIDTH; b++) begin
            mem_rd_addr[b] = idx[BIT_WIDTH-1-b];
        end
    end
`else
    assign mem_rd_addr = idx;
`endif

    // Frame sequencing, read tracking and registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            pend_idx   <= '0;
            rd_pending <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            rd_pending <= mem_rd_en;
            if (mem_rd_en) begin
                pend_idx <= idx;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_rd_en) begin
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Finish when the FIFO empties this cycle with nothing in flight.
                    if (!rd_pending && (fifo_count == 2'(pop))) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_wr_data = {mem_rd_data, pend_idx, (pend_idx == LAST_IDX)};

    fft_bin_skid_fifo #(
        .WIDTH (PW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (rd_pending),
        .wr_data  (fifo_wr_data),
        .count    (fifo_count),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (fifo_rd_data)
    );

    assign {m_data, m_index, m_last} = fifo_rd_data;

endmodule

// File: tb/tb_fft_bin_reader.sv
// Directed bench for fft_bin_reader with N=16 and a RAM returning 0xA000+addr.
module tb_fft_bin_reader;

    localparam int BW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [BW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_index;
    logic          m_last;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fft_bin_reader #(
        .BIT_WIDTH  (BW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_index     (m_index),
        .m_last      (m_last)
    );

    // Bin RAM model: one-cycle read latency, poison when not read.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? (32'hA000 + 32'(mem_rd_addr)) : 32'hDEAD_BEEF;
    end

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // RAM address expected for natural bin i.
    function automatic logic [3:0] exp_addr(input int i);
        logic [3:0] n;
        n = 4'(i);
`ifdef FFT_BIN_READER_BITREV_EN
        return rev4(n);
`else
        return n;
`endif
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        return 32'hA000 + 32'(exp_addr(i));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        start;
        logic        busy_chk;
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [3:0]  addr;
        logic        valid;
        logic [3:0]  index;
        logic [31:0] data;
        logic        last;
    } vec_t;

    vec_t tbl[22];

    // One frame: optional ready percentage, optional second start, optional done cycle.
    task automatic run_frame(input int ready_pct, input int restart_at, input int exp_done_cycle);
        int next_idx = 0;
        int issued = 0;
        int accepted = 0;
        int dones = 0;
        int done_cyc = -1;
        logic stalled = 1'b0;
        logic [31:0] h_data = '0;
        logic [3:0] h_idx = '0;
        logic h_last = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start   = (cyc == 0) || (cyc == restart_at);
            m_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (mem_rd_en) begin
                check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr(issued)));
                issued++;
            end
            if (m_valid && stalled) begin
                check("stall_data", m_data, h_data);
                check("stall_index", 32'(m_index), 32'(h_idx));
                check("stall_last", 32'(m_last), 32'(h_last));
            end
            if (m_valid && m_ready) begin
                check("beat_index", 32'(m_index), 32'(next_idx));
                check("beat_data", m_data, exp_data(next_idx));
                check("beat_last", 32'(m_last), 32'(next_idx == 15));
                next_idx++;
                accepted++;
            end
            check("buffered_le2", 32'((issued - accepted) <= 2), 32'd1);
            stalled = m_valid && !m_ready;
            h_data  = m_data;
            h_idx   = m_index;
            h_last  = m_last;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start   = 1'b0;
        m_ready = 1'b0;
        check("frame_dones", 32'(dones), 32'd1);
        check("frame_beats", 32'(accepted), 32'd16);
        check("frame_reads", 32'(issued), 32'd16);
        if (exp_done_cycle >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_done_cycle));
    endtask

    initial begin
        // Table for a back-to-back frame: start in cycle 0, m_ready held high.
        for (int k = 0; k < 22; k++) begin
            tbl[k].start    = (k == 0);
            tbl[k].busy_chk = (k != 19);
            tbl[k].busy     = (k >= 1 && k <= 18);
            tbl[k].done     = (k == 19);
            tbl[k].rd_en    = (k >= 1 && k <= 16);
            tbl[k].addr     = (k >= 1 && k <= 16) ? exp_addr(k - 1) : 4'd0;
            tbl[k].valid    = (k >= 3 && k <= 18);
            tbl[k].index    = (k >= 3 && k <= 18) ? 4'(k - 3) : 4'd0;
            tbl[k].data     = (k >= 3 && k <= 18) ? exp_data(k - 3) : 32'd0;
            tbl[k].last     = (k == 18);
        end

        reset   = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_index", 32'(m_index), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 22; k++) begin
            start   = tbl[k].start;
            m_ready = 1'b1;
            @(negedge clk);
            if (tbl[k].busy_chk) check("tbl_busy", 32'(busy), 32'(tbl[k].busy));
            check("tbl_done", 32'(done), 32'(tbl[k].done));
            check("tbl_rd_en", 32'(mem_rd_en), 32'(tbl[k].rd_en));
            if (tbl[k].rd_en) check("tbl_addr", 32'(mem_rd_addr), 32'(tbl[k].addr));
            check("tbl_valid", 32'(m_valid), 32'(tbl[k].valid));
            if (tbl[k].valid) begin
                check("tbl_index", 32'(m_index), 32'(tbl[k].index));
                check("tbl_data", m_data, tbl[k].data);
                check("tbl_last", 32'(m_last), 32'(tbl[k].last));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // Known bins for the storage order in use.
`ifdef FFT_BIN_READER_BITREV_EN
        check("bitrev_bin1", exp_data(1), 32'hA008);
        check("bitrev_bin3", exp_data(3), 32'hA00C);
`else
        check("natural_bin1", exp_data(1), 32'hA001);
`endif

        // Reset in the middle of a frame, right after beat 7 is accepted.
        for (int cyc = 0; cyc <= 10; cyc++) begin
            start   = (cyc == 0);
            m_ready = 1'b1;
            @(negedge clk);
            if (cyc == 10) begin
                check("mid_beat7_valid", 32'(m_valid), 32'd1);
                check("mid_beat7_index", 32'(m_index), 32'd7);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mid_rst_addr", 32'(mem_rd_addr), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", m_data, 32'd0);
        check("mid_rst_index", 32'(m_index), 32'd0);
        check("mid_rst_last", 32'(m_last), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_discard", 32'(m_valid), 32'd0);
        check("post_rst_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        run_frame(100, -1, 19);

        // Random backpressure.
        run_frame(70, -1, -1);
        run_frame(40, -1, -1);

        // Second start during the frame must be ignored.
        run_frame(100, 5, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
